// File: rtl/umi_rr_arbiter_pkg.sv
// Shared UMI constants: default stream count and field widths for UMI blocks.
package umi_rr_arbiter_pkg;

    localparam int unsigned UmiNin      = 2;
    localparam int unsigned UmiDw       = 256;
    localparam int unsigned UmiAw       = 64;
    localparam int unsigned UmiCw       = 32;
    localparam int unsigned UmiMaxBurst = 1;

endpackage

// File: rtl/umi_rr_pick.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping modulo NIN.
module umi_rr_pick #(
    parameter int unsigned NIN = 2,
    localparam int unsigned IW = $clog2(NIN)
) (
    input  logic [NIN-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [NIN-1:0] gnt,
    output logic [IW-1:0]  idx
);

    logic          found;
    logic [IW-1:0] pos;

    // Scan ptr+1, ptr+2, ... ptr+NIN (ptr itself last) and take the first requester.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned k = 1; k <= NIN; k++) begin
            pos = IW'((32'(ptr) + k) % NIN);
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/umi_rr_arbiter.sv
// Round-robin merge of NIN single-beat UMI streams onto one registered UMI output,
// with an optional burst lock that keeps the current winner for up to MAXBURST beats.
module umi_rr_arbiter
    import umi_rr_arbiter_pkg::*;
#(
    parameter int unsigned NIN      = UmiNin,
    parameter int unsigned DW       = UmiDw,
    parameter int unsigned AW       = UmiAw,
    parameter int unsigned CW       = UmiCw,
    parameter int unsigned MAXBURST = UmiMaxBurst
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NIN-1:0]    umi_in_valid,
    input  logic [NIN*CW-1:0] umi_in_cmd,
    input  logic [NIN*AW-1:0] umi_in_dstaddr,
    input  logic [NIN*AW-1:0] umi_in_srcaddr,
    input  logic [NIN*DW-1:0] umi_in_data,
    output logic [NIN-1:0]    umi_in_ready,
    output logic              umi_out_valid,
    output logic [CW-1:0]     umi_out_cmd,
    output logic [AW-1:0]     umi_out_dstaddr,
    output logic [AW-1:0]     umi_out_srcaddr,
    output logic [DW-1:0]     umi_out_data,
    input  logic              umi_out_ready
);

    localparam int unsigned IW   = $clog2(NIN);
    localparam int unsigned CntW = $clog2(MAXBURST + 1);

    logic            out_valid_q;
    logic [CW-1:0]   out_cmd_q;
    logic [AW-1:0]   out_dstaddr_q;
    logic [AW-1:0]   out_srcaddr_q;
    logic [DW-1:0]   out_data_q;
    logic [IW-1:0]   last_grant_q;
    logic [CntW-1:0] burst_cnt_q;

    logic            room;
    logic            lock;
    logic            take;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   pick_idx;
    logic [NIN-1:0]  pick_gnt;

    umi_rr_pick #(
        .NIN(NIN)
    ) u_pick (
        .req(umi_in_valid),
        .ptr(last_grant_q),
        .gnt(pick_gnt),
        .idx(pick_idx)
    );

    assign room = ~out_valid_q | umi_out_ready;
    // burst_cnt==0 only between reset and the first grant; no burst is in progress then,
    // so the lock stays off and input 0 wins first.
    assign lock = (burst_cnt_q != '0) & (burst_cnt_q < CntW'(MAXBURST))
                & umi_in_valid[last_grant_q];
    assign sel  = lock ? last_grant_q : pick_idx;
    assign take = room & umi_in_valid[sel];

    // Grant the selected input only; the picker one-hot equals sel whenever lock is off.
    always_comb begin
        umi_in_ready = '0;
        if (take) begin
            umi_in_ready = lock ? (NIN'(1) << last_grant_q) : pick_gnt;
        end
    end

    // Output register, round-robin pointer and burst counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_cmd_q     <= '0;
            out_dstaddr_q <= '0;
            out_srcaddr_q <= '0;
            out_data_q    <= '0;
            last_grant_q  <= IW'(NIN - 1);
            burst_cnt_q   <= '0;
        end else begin
            if (room) begin
                out_valid_q <= take;
            end
            if (take) begin
                out_cmd_q     <= umi_in_cmd[32'(sel) * CW +: CW];
                out_dstaddr_q <= umi_in_dstaddr[32'(sel) * AW +: AW];
                out_srcaddr_q <= umi_in_srcaddr[32'(sel) * AW +: AW];
                out_data_q    <= umi_in_data[32'(sel) * DW +: DW];
                if (sel == last_grant_q) begin
                    if (burst_cnt_q < CntW'(MAXBURST)) begin
                        burst_cnt_q <= burst_cnt_q + CntW'(1);
                    end
                end else begin
                    burst_cnt_q  <= CntW'(1);
                    last_grant_q <= sel;
                end
            end
        end
    end

    assign umi_out_valid   = out_valid_q;
    assign umi_out_cmd     = out_cmd_q;
    assign umi_out_dstaddr = out_dstaddr_q;
    assign umi_out_srcaddr = out_srcaddr_q;
    assign umi_out_data    = out_data_q;

endmodule
